// File: rtl/serial_port.sv
// serial_port: byte UART on clk, fixed baud of clk/DIVISOR, 8N1 LSB first, separate TX and RX FSMs.
// Define SERIAL_PARITY_EN to insert and check an even-parity bit after data bit 7 (8E1 framing).
module serial_port #(
    parameter int DIVISOR = 312,
    parameter int CNTBITS = $clog2(DIVISOR)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       rx_overrun,
    output logic       rx_frame_err,
    input  logic       err_clr
);
    localparam logic [CNTBITS-1:0] BIT_LAST  = CNTBITS'(DIVISOR - 1);
    localparam logic [CNTBITS-1:0] HALF_LAST = CNTBITS'(DIVISOR / 2 - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    if (DIVISOR < 4) begin : g_bad_divisor
        always_ff @(posedge clk) $error("serial_port: DIVISOR=%0d is below the minimum of 4", DIVISOR);
    end

    tx_state_t          tx_state_q, tx_state_d;
    logic [CNTBITS-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]         tx_bit_q, tx_bit_d;
    logic [7:0]         tx_shift_q, tx_shift_d;
    logic               txd_q, txd_d;
    logic               tx_tick;
`ifdef SERIAL_PARITY_EN
    logic               tx_par_q, tx_par_d;
`endif

    assign tx_tick = (tx_cnt_q == '0);
    assign txd     = txd_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_tick ? BIT_LAST : tx_cnt_q - CNTBITS'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_ready   = 1'b0;
        txd_d      = 1'b1;
`ifdef SERIAL_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        case (tx_state_q)
            TX_IDLE:  tx_ready = 1'b1;
            TX_START: if (tx_tick) begin
                tx_state_d = TX_DATA;
                tx_bit_d   = '0;
            end
            TX_DATA: if (tx_tick) begin
                tx_shift_d = {1'b0, tx_shift_q[7:1]};
                tx_bit_d   = tx_bit_q + 3'd1;
`ifdef SERIAL_PARITY_EN
                if (tx_bit_q == 3'd7) tx_state_d = TX_PAR;
`else
                if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
`endif
            end
`ifdef SERIAL_PARITY_EN
            TX_PAR: if (tx_tick) tx_state_d = TX_STOP;
`endif
            TX_STOP: begin
                tx_ready = tx_tick;
                if (tx_tick) tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
        // An accept on the last STOP cycle chains straight into the next START.
        if (tx_valid && tx_ready) begin
            tx_state_d = TX_START;
            tx_cnt_d   = BIT_LAST;
            tx_shift_d = tx_data;
`ifdef SERIAL_PARITY_EN
            tx_par_d   = ^tx_data;
`endif
        end
        // txd is registered from the next state so the pin never glitches.
        case (tx_state_d)
            TX_START: txd_d = 1'b0;
            TX_DATA:  txd_d = tx_shift_d[0];
`ifdef SERIAL_PARITY_EN
            TX_PAR:   txd_d = tx_par_d;
`endif
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
`ifdef SERIAL_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
`ifdef SERIAL_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    rx_state_t          rx_state_q, rx_state_d;
    logic [CNTBITS-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]         rx_bit_q, rx_bit_d;
    logic [7:0]         rx_shift_q, rx_shift_d;
    logic               rxd_s1_q, rxd_s2_q;
    logic [7:0]         rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               rx_overrun_q, rx_overrun_d;
    logic               rx_frame_err_q, rx_frame_err_d;
    logic               rx_tick, deliver, frame_evt, overrun_evt;
`ifdef SERIAL_PARITY_EN
    logic               rx_par_err_q, rx_par_err_d;
`endif

    assign rx_tick      = (rx_cnt_q == '0);
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_overrun   = rx_overrun_q;
    assign rx_frame_err = rx_frame_err_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_tick ? BIT_LAST : rx_cnt_q - CNTBITS'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        deliver    = 1'b0;
        frame_evt  = 1'b0;
`ifdef SERIAL_PARITY_EN
        rx_par_err_d = rx_par_err_q;
`endif
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = HALF_LAST;
                if (!rxd_s2_q) rx_state_d = RX_START;
            end
            RX_START: if (rx_tick) begin
                rx_state_d = rxd_s2_q ? RX_IDLE : RX_DATA;
                rx_bit_d   = '0;
            end
            RX_DATA: if (rx_tick) begin
                rx_shift_d = {rxd_s2_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 3'd1;
`ifdef SERIAL_PARITY_EN
                if (rx_bit_q == 3'd7) rx_state_d = RX_PAR;
`else
                if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
`endif
            end
`ifdef SERIAL_PARITY_EN
            RX_PAR: if (rx_tick) begin
                rx_par_err_d = rxd_s2_q ^ (^rx_shift_q);
                frame_evt    = rx_par_err_d;
                rx_state_d   = RX_STOP;
            end
`endif
            RX_STOP: if (rx_tick) begin
                if (!rxd_s2_q) begin
                    frame_evt  = 1'b1;
                    rx_state_d = RX_WAIT_HIGH;
                end else begin
                    rx_state_d = RX_IDLE;
`ifdef SERIAL_PARITY_EN
                    deliver    = !rx_par_err_q;
`else
                    deliver    = 1'b1;
`endif
                end
            end
            RX_WAIT_HIGH: if (rxd_s2_q) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase

        // A delivery with an ack in the same cycle replaces the byte instead of overrunning.
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q && !rx_ack;
        overrun_evt = deliver && rx_valid_q && !rx_ack;
        if (deliver && !overrun_evt) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
        end
        rx_overrun_d   = (rx_overrun_q && !err_clr) || overrun_evt;
        rx_frame_err_d = (rx_frame_err_q && !err_clr) || frame_evt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_s1_q       <= 1'b1;
            rxd_s2_q       <= 1'b1;
            rx_state_q     <= RX_IDLE;
            rx_cnt_q       <= '0;
            rx_bit_q       <= '0;
            rx_shift_q     <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rx_overrun_q   <= 1'b0;
            rx_frame_err_q <= 1'b0;
`ifdef SERIAL_PARITY_EN
            rx_par_err_q   <= 1'b0;
`endif
        end else begin
            rxd_s1_q       <= rxd;
            rxd_s2_q       <= rxd_s1_q;
            rx_state_q     <= rx_state_d;
            rx_cnt_q       <= rx_cnt_d;
            rx_bit_q       <= rx_bit_d;
            rx_shift_q     <= rx_shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rx_overrun_q   <= rx_overrun_d;
            rx_frame_err_q <= rx_frame_err_d;
`ifdef SERIAL_PARITY_EN
            rx_par_err_q   <= rx_par_err_d;
`endif
        end
    end
endmodule

// File: tb/tb_serial_port.sv
// tb_serial_port: self-checking bench for serial_port at DIVISOR=8 (8N1, or 8E1 with SERIAL_PARITY_EN).
module tb_serial_port;
    localparam int D = 8;
`ifdef SERIAL_PARITY_EN
    localparam int NBITS = 11;
    localparam bit PAR   = 1'b1;
`else
    localparam int NBITS = 10;
    localparam bit PAR   = 1'b0;
`endif
    localparam int FRAME       = NBITS * D;
    localparam int STOP_SAMPLE = 3 + D / 2 + (NBITS - 1) * D;
    localparam int LAT_NOM     = 2 + (D * (2 * NBITS - 1)) / 2;

    logic       clk = 1'b0;
    logic       reset_n, tx_valid, tx_ready, txd, rxd_drv, rxd_w, loop_en;
    logic [7:0] tx_data, rx_data;
    logic       rx_valid, rx_ack, rx_overrun, rx_frame_err, err_clr;
    int         n_tests = 0;
    int         n_fail  = 0;

    typedef struct {
        logic [7:0] data;
        logic       stop_b;
        logic       flip;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_ferr;
    } rx_vec_t;

    rx_vec_t    rx_tab[$];
    logic [7:0] tx_vec[$];
    logic [7:0] lb_q[$];

    assign rxd_w = loop_en ? txd : rxd_drv;
    always #5 clk = ~clk;

    serial_port #(.DIVISOR(D)) dut (
        .clk(clk), .reset_n(reset_n),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .txd(txd),
        .rxd(rxd_w), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
        .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err), .err_clr(err_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Line level of bit slot idx of a frame: start, 8 data LSB first, [even parity], stop.
    function automatic logic frame_bit(input logic [7:0] d, input int idx, input logic stop_b, input logic flip);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (idx == NBITS - 1) return stop_b;
        return (^d) ^ flip;
    endfunction

    // Entered with tx_valid high at a negedge while tx_ready=1; checks every cycle of the frame.
    task automatic tx_frame(input logic [7:0] d, input logic chain, input logic [7:0] next_d);
        int bad = 0;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            if (txd !== frame_bit(d, (k - 1) / D, 1'b1, 1'b0)) bad++;
            if (tx_ready !== (k == FRAME)) bad++;
            if (k == FRAME && chain) begin
                tx_valid = 1'b1;
                tx_data  = next_d;
            end
        end
        check($sformatf("tx_frame_%02h bad_cycles", d), bad, 0);
    endtask

    // Entered at a negedge; drives one frame plus idle on rxd, optionally pulsing rx_ack at cycle ack_at.
    task automatic rx_send(input logic [7:0] d, input logic stop_b, input logic flip, input int ack_at);
        for (int c = 0; c < FRAME + 2 * D; c++) begin
            rxd_drv = (c < FRAME) ? frame_bit(d, c / D, stop_b, flip) : 1'b1;
            rx_ack  = (c == ack_at);
            @(negedge clk);
        end
        rx_ack = 1'b0;
    endtask

    task automatic clear_rx();
        rx_ack  = 1'b1;
        err_clr = 1'b1;
        @(negedge clk);
        rx_ack  = 1'b0;
        err_clr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        logic [7:0] nd, d;
        logic stp, flp, ok;

        tx_vec = '{8'hA5, 8'h00, 8'hFF, 8'h3C, 8'h07};
        rx_tab.push_back(rx_vec_t'{8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0});
        rx_tab.push_back(rx_vec_t'{8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0});
        rx_tab.push_back(rx_vec_t'{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0});
        rx_tab.push_back(rx_vec_t'{8'h96, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1});
        rx_tab.push_back(rx_vec_t'{8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0});
`ifdef SERIAL_PARITY_EN
        rx_tab.push_back(rx_vec_t'{8'h07, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1});
        rx_tab.push_back(rx_vec_t'{8'h07, 1'b1, 1'b0, 1'b1, 8'h07, 1'b0});
`endif

        reset_n = 1'b0; tx_valid = 1'b0; tx_data = '0; rxd_drv = 1'b1; loop_en = 1'b0;
        rx_ack = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst txd", txd, 1);
        check("rst tx_ready", tx_ready, 1);
        check("rst rx_valid", rx_valid, 0);
        check("rst rx_data", rx_data, 0);
        check("rst rx_overrun", rx_overrun, 0);
        check("rst rx_frame_err", rx_frame_err, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Transmit table, back-to-back accepts with no idle gap.
        tx_valid = 1'b1;
        tx_data  = tx_vec[0];
        for (int i = 0; i < tx_vec.size(); i++) begin
            nd = (i + 1 < tx_vec.size()) ? tx_vec[(i + 1) % tx_vec.size()] : 8'h00;
            tx_frame(tx_vec[i], i + 1 < tx_vec.size(), nd);
        end
        @(negedge clk);
        check("tx idle txd", txd, 1);
        check("tx idle ready", tx_ready, 1);

        // Receive table driven directly on rxd.
        for (int i = 0; i < rx_tab.size(); i++) begin
            rx_send(rx_tab[i].data, rx_tab[i].stop_b, rx_tab[i].flip, -1);
            check($sformatf("rx_tab%0d valid", i), rx_valid, rx_tab[i].exp_valid);
            if (rx_tab[i].exp_valid) check($sformatf("rx_tab%0d data", i), rx_data, rx_tab[i].exp_data);
            check($sformatf("rx_tab%0d frame_err", i), rx_frame_err, rx_tab[i].exp_ferr);
            clear_rx();
            check($sformatf("rx_tab%0d ack clears", i), rx_valid, 0);
            check($sformatf("rx_tab%0d err_clr", i), rx_frame_err, 0);
        end

        // Loopback with latency window from the start edge.
        loop_en  = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        lat = 0;
        while (!rx_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        check("lb rx_valid", rx_valid, 1);
        check("lb rx_data", rx_data, 8'h3C);
        check("lb latency in window", ((lat - 1) >= LAT_NOM - 2) && ((lat - 1) <= LAT_NOM + 2), 1);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        check("lb ack clears", rx_valid, 0);
        repeat (2 * D) @(negedge clk);
        loop_en = 1'b0;

        // Overrun, err_clr, and ack coinciding with delivery.
        rx_send(8'h11, 1'b1, 1'b0, -1);
        check("ovr first valid", rx_valid, 1);
        check("ovr first data", rx_data, 8'h11);
        rx_send(8'h22, 1'b1, 1'b0, -1);
        check("ovr data kept", rx_data, 8'h11);
        check("ovr flag", rx_overrun, 1);
        check("ovr valid kept", rx_valid, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("ovr err_clr", rx_overrun, 0);
        rx_send(8'hB2, 1'b1, 1'b0, STOP_SAMPLE - 1);
        check("ack+deliver data", rx_data, 8'hB2);
        check("ack+deliver valid", rx_valid, 1);
        check("ack+deliver no overrun", rx_overrun, 0);
        clear_rx();

        // False start, then a break condition followed by a clean byte.
        rxd_drv = 1'b0;
        repeat (3) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (20) @(negedge clk);
        check("false start valid", rx_valid, 0);
        check("false start ferr", rx_frame_err, 0);
        check("false start ovr", rx_overrun, 0);
        rxd_drv = 1'b0;
        repeat (150) @(negedge clk);
        check("break ferr", rx_frame_err, 1);
        check("break valid", rx_valid, 0);
        repeat (50) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (4) @(negedge clk);
        rx_send(8'h55, 1'b1, 1'b0, -1);
        check("after break valid", rx_valid, 1);
        check("after break data", rx_data, 8'h55);
        clear_rx();
        check("after break err_clr", rx_frame_err, 0);

        // Reset during the start bit of a transmit aborts the frame immediately.
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("pre-reset txd low", txd, 0);
        reset_n = 1'b0;
        #1;
        check("mid reset txd", txd, 1);
        check("mid reset tx_ready", tx_ready, 1);
        @(negedge clk);
        reset_n  = 1'b1;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h5A;
        tx_frame(8'h5A, 1'b0, 8'h00);

        // Random loopback against a FIFO of sent bytes.
        loop_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            d = 8'($urandom);
            lb_q.push_back(d);
            tx_valid = 1'b1;
            tx_data  = d;
            @(posedge clk);
            #1 tx_valid = 1'b0;
            lat = 0;
            while (!rx_valid && lat < 300) begin
                @(negedge clk);
                lat++;
            end
            check($sformatf("rand lb%0d data", i), {rx_valid, rx_frame_err, rx_data}, {2'b10, lb_q.pop_front()});
            clear_rx();
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        loop_en = 1'b0;
        @(negedge clk);

        // Random frames on rxd with occasional bad stop or parity.
        for (int i = 0; i < 12; i++) begin
            d   = 8'($urandom);
            stp = ($urandom_range(0, 3) != 0);
            flp = PAR && ($urandom_range(0, 3) == 0);
            ok  = stp && !flp;
            rx_send(d, stp, flp, -1);
            check($sformatf("rand rx%0d valid", i), rx_valid, ok);
            if (ok) check($sformatf("rand rx%0d data", i), rx_data, d);
            check($sformatf("rand rx%0d ferr", i), rx_frame_err, !ok);
            clear_rx();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_port.md
Name: serial_port

Overview:
- Byte-oriented UART on the system clock `clk` (3 MHz from the board clock divider).
- Sits downstream of the system on the board serial pins: TXD drives TX, RXD samples RX.
- Replaces bit-banging those pins through the third GPIO port.
- Frame format: 8N1, LSB first, fixed baud set by parameter; separate transmit and receive state machines.

Parameters:
- DIVISOR, 312, clk cycles per bit (3 MHz / 312 ≈ 9615 baud); legal range 4..65535.
- CNTBITS, $clog2(DIVISOR), width of bit-timing counters.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset_n  input  1  asynchronous active-low reset.
- tx_data  input  8  byte to transmit.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  transmitter can accept a byte.
- txd  output  1  serial out, idle high.
- rxd  input  1  serial in, asynchronous to clk.
- rx_data  output  8  last received byte.
- rx_valid  output  1  rx_data holds an unread byte.
- rx_ack  input  1  consumer has read rx_data.
- rx_overrun  output  1  sticky: a byte was lost because rx_valid was still set.
- rx_frame_err  output  1  sticky: bad stop bit (or parity, see Optional Feature).
- err_clr  input  1  clears both sticky error flags.

Behaviour:
- Reset is asynchronous, active-low: drives txd=1, tx_ready=1, rx_data=0, rx_valid=0, rx_overrun=0, rx_frame_err=0.
  - Both FSMs go to IDLE; the rxd synchronizer flops go to 1.
  - Reset asserted mid-frame aborts the frame; txd returns high immediately.

Transmit FSM: IDLE -> START -> DATA -> STOP -> IDLE.
- Accept occurs on the edge where tx_valid && tx_ready.
  - tx_data is latched into the shift register.
  - tx_ready goes 0 the next cycle.
- START: txd=0 for DIVISOR cycles, beginning the cycle after accept.
- DATA: 8 bits, LSB first, DIVISOR cycles each; a bit counter 0..7 counts them.
- STOP: txd=1 for DIVISOR cycles; tx_ready returns 1 on the last STOP cycle.
- Total frame is exactly 10*DIVISOR cycles, accept to next possible accept.
- Back-to-back: an accept on the cycle tx_ready is high starts the next START with no idle gap.
- tx_data and tx_valid are ignored while tx_ready=0.

Receive path and FSM: rxd passes through a 2-flop synchronizer; the FSM uses the synchronized value only.
- FSM states: IDLE -> START -> DATA -> STOP -> IDLE, plus WAIT_HIGH.
- IDLE: synchronized rxd=0 enters START and loads the counter.
- START: samples at DIVISOR/2 (integer division) cycles.
  - Sample 1 = false start: return to IDLE, no flags set.
  - Sample 0: enter DATA.
- DATA: samples each bit every DIVISOR cycles after the start-bit centre; 8 samples shift in LSB first.
- STOP: samples DIVISOR cycles after the last data sample.
  - Sample 1: deliver the byte, go to IDLE.
  - Sample 0: set rx_frame_err, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until synchronized rxd=1 (break condition), then IDLE.
- Delivery: rx_data and rx_valid=1 update the cycle after the stop-bit sample.
  - If rx_valid=1 and no rx_ack in the same cycle: set rx_overrun, drop the new byte, keep the old rx_data.
  - rx_ack with rx_valid=1 and no delivery: rx_valid=0 next cycle.
  - rx_ack and delivery in the same cycle: load the new byte, rx_valid stays 1, no overrun.
  - rx_ack while rx_valid=0 has no effect.
- err_clr clears both sticky flags next cycle. If an error event coincides with err_clr, the flag is set (set wins).

Arithmetic:
- Counters are CNTBITS wide and count down to 0; no wrap is ever reached.
- DIVISOR < 4 is a configuration error; flag it with a simulation-time $error.

Optional Feature:
SERIAL_PARITY_EN
- Defined: an even-parity bit is inserted between data bit 7 and the stop bit.
  - Frame becomes 11*DIVISOR cycles.
  - RX samples the parity bit; on mismatch it sets rx_frame_err and discards the byte. It still checks the stop bit and uses WAIT_HIGH if that bit is 0.
- Undefined: 8N1 exactly as above; no parity logic present.

Test Plan (DIVISOR=8 unless stated):
- Reset released, tx_valid=1 with tx_data=8'hA5 -> txd shows 0,1,0,1,0,0,1,0,1,1, each held 8 cycles; tx_ready=0 for 80 cycles; txd=1 after.
- txd looped to rxd, send 8'h3C -> rx_valid=1, rx_data=8'h3C, 2+8*9.5 cycles (±2) after the start edge; rx_ack clears rx_valid next cycle.
- Two bytes 8'h11, 8'h22 received without rx_ack -> rx_data stays 8'h11, rx_overrun=1; err_clr -> rx_overrun=0.
- rxd low pulse of 3 cycles -> false start, rx_valid stays 0, no flags; rxd held low 200 cycles -> rx_frame_err=1, no byte, FSM waits for rxd high, then receives 8'h55 correctly.
- reset_n pulsed low mid-transmit of 8'hFF -> txd=1 and tx_ready=1 immediately; the next accepted byte transmits a full frame.
- With SERIAL_PARITY_EN, send 8'h07 -> parity bit 1, frame 88 cycles; inject a flipped parity bit on rxd -> rx_frame_err=1, no rx_valid.
